// File: rtl/md_pkg.sv
// Shared decode constants and encodings for the iterative multiply/divide unit.
package md_pkg;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_kind_e;

  // True for the four Funct codes that launch a multi-cycle operation.
  function automatic logic is_muldiv(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
module md_iter_core
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  op_kind_e               kind,
  input  logic [2*WIDTH-1:0]     acc,
  input  logic [WIDTH-1:0]       opnd,
  output logic [2*WIDTH-1:0]     acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  always_comb begin
    mul_sum   = '0;
    div_trial = '0;
    div_ge    = 1'b0;
    div_rem   = '0;
    acc_next  = acc;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};

    // Divide: acc = {remainder, remaining dividend bits / quotient bits}.
    div_trial = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_trial >= {1'b0, opnd});
    div_rem   = div_ge ? (div_trial[WIDTH-1:0] - opnd) : div_trial[WIDTH-1:0];

    if (kind == OP_MUL) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {div_rem, acc[WIDTH-2:0], div_ge};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers for the execute stage.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_e            state;
  state_e            state_d;
  logic              issue_md;
  logic              wr_mthi;
  logic              wr_mtlo;

  op_kind_e          kind;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [WIDTH-1:0]  opnd;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic [CNT_W-1:0]  cnt;

  logic              is_signed;
  logic              is_div;
  logic              a_neg;
  logic              b_neg;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;

  logic [ACC_W-1:0]  prod_fix;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  fix_hi;
  logic [WIDTH-1:0]  fix_lo;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    issue_md = 1'b0;
    wr_mthi  = 1'b0;
    wr_mtlo  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          wr_mthi = (Funct == FN_MTHI);
          wr_mtlo = (Funct == FN_MTLO);
          if (is_muldiv(Funct)) begin
            issue_md = 1'b1;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand magnitudes and signs, only meaningful on the issuing edge.
  always_comb begin
    is_signed = ~Funct[0];
    is_div    = (Funct == FN_DIV) || (Funct == FN_DIVU);
    a_neg     = is_signed & op_a[WIDTH-1];
    b_neg     = is_signed & op_b[WIDTH-1];
    a_mag     = a_neg ? (-op_a) : op_a;
    b_mag     = b_neg ? (-op_b) : op_b;
  end

  md_iter_core #(
    .WIDTH (WIDTH)
  ) u_iter (
    .kind     (kind),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  // Sign fix-up; divide-by-zero keeps the all-ones quotient unnegated.
  always_comb begin
    prod_fix = neg_q ? (-acc) : acc;
    quo      = acc[WIDTH-1:0];
    rem      = acc[ACC_W-1:WIDTH];
    if (kind == OP_MUL) begin
      fix_hi = prod_fix[ACC_W-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else begin
      fix_hi = neg_r ? (-rem) : rem;
      fix_lo = div_zero ? {WIDTH{1'b1}} : (neg_q ? (-quo) : quo);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kind     <= OP_MUL;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == ST_FIX);
      if (issue_md) begin
        kind     <= is_div ? OP_DIV : OP_MUL;
        acc      <= is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
        opnd     <= is_div ? b_mag : a_mag;
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        div_zero <= (op_b == '0);
        cnt      <= '0;
      end else if (state == ST_RUN) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
      end
      if (wr_mthi) hi <= op_a;
      if (wr_mtlo) lo <= op_a;
      if (state == ST_FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, results checked on done by a monitor.
module tb_mul_div_unit;

  localparam int unsigned W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   Funct = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Funct (Funct),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } sb_t;

  typedef struct {
    string        name;
    bit           chk_hilo;
    logic         busy_e;
    logic         done_e;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } probe_t;

  sb_t    sb_q[$];
  probe_t pr_q[$];
  int     n_pass = 0;
  int     n_total = 0;
  bit     finish_req = 1'b0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endfunction

  // Monitor: immediate probes first, then scoreboard pop on every done pulse.
  always @(negedge clk) begin
    probe_t p;
    sb_t    s;
    while (pr_q.size() > 0) begin
      p = pr_q.pop_front();
      check({p.name, ".busy"}, W'(busy), W'(p.busy_e));
      check({p.name, ".done"}, W'(done), W'(p.done_e));
      if (p.chk_hilo) begin
        check({p.name, ".hi"}, hi, p.hi);
        check({p.name, ".lo"}, lo, p.lo);
      end
    end
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL spurious_done: got done=1 expected no result pending");
      end else begin
        s = sb_q.pop_front();
        check({s.name, ".hi"}, hi, s.hi);
        check({s.name, ".lo"}, lo, s.lo);
      end
    end
    if (finish_req) begin
      check("sb_drained", W'(sb_q.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(string n, logic b, logic d, bit chk, logic [W-1:0] h, logic [W-1:0] l);
    probe_t p;
    p.name = n; p.busy_e = b; p.done_e = d; p.chk_hilo = chk; p.hi = h; p.lo = l;
    pr_q.push_back(p);
  endtask

  task automatic expect_result(string n, logic [W-1:0] h, logic [W-1:0] l);
    sb_t s;
    s.name = n; s.hi = h; s.lo = l;
    sb_q.push_back(s);
  endtask

  // Operands are scrambled after the issue edge since only latched copies matter.
  task automatic issue(logic [5:0] fn, logic [W-1:0] a, logic [W-1:0] b);
    start = 1'b1; Funct = fn; op_a = a; op_b = b;
    step();
    start = 1'b0; Funct = 6'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_done(string n);
    int k = 0;
    while (done !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    if (done !== 1'b1) probe({n, "_timeout"}, 1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic run_md(string n, logic [5:0] fn, logic [W-1:0] a, logic [W-1:0] b,
                        logic [W-1:0] eh, logic [W-1:0] el);
    expect_result(n, eh, el);
    issue(fn, a, b);
    wait_done(n);
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    step(); step();
    probe("reset_state", 1'b0, 1'b0, 1'b1, '0, '0);
    step();
    reset = 1'b1;
    step();

    // MULT -7 * 3 with cycle-accurate busy/done timing
    expect_result("mult_m7x3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(F_MULT, 32'hFFFF_FFF9, 32'd3);
    probe("mult_c1", 1'b1, 1'b0, 1'b0, '0, '0);
    repeat (32) step();
    probe("mult_c33", 1'b1, 1'b0, 1'b0, '0, '0);
    step();
    probe("mult_c34", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    step();
    probe("mult_c35", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // MULTU max*max, then MULT issued in the done cycle
    run_md("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    expect_result("mult_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFEC);
    issue(F_MULT, 32'd5, 32'hFFFF_FFFC);
    probe("b2b_busy", 1'b1, 1'b0, 1'b0, '0, '0);
    wait_done("mult_b2b");

    run_md("div_m7d2",   F_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu_7d2",   F_DIVU, 32'd7,         32'd2,        32'd1,         32'd3);
    run_md("div_7dm2",   F_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);
    run_md("divu_by0",   F_DIVU, 32'h64,        32'd0,        32'h64,        32'hFFFF_FFFF);
    run_md("div_m8_by0", F_DIV,  32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF);
    run_md("div_ovf",    F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000);
    step();

    // MTHI/MTLO while idle, and an unrelated Funct that must do nothing
    issue(F_MTHI, 32'h1234, 32'h0);
    cur_hi = 32'h1234;
    probe("mthi_idle", 1'b0, 1'b0, 1'b1, cur_hi, cur_lo);
    issue(F_MTLO, 32'h5678, 32'h0);
    cur_lo = 32'h5678;
    probe("mtlo_idle", 1'b0, 1'b0, 1'b1, cur_hi, cur_lo);
    issue(6'b100000, 32'hAAAA_AAAA, 32'h5);
    probe("bad_funct", 1'b0, 1'b0, 1'b1, cur_hi, cur_lo);

    // Starts while busy are dropped, including MTLO
    expect_result("mult_2x3", 32'h0, 32'h6);
    issue(F_MULT, 32'd2, 32'd3);
    repeat (3) step();
    issue(F_MTLO, 32'hDEAD_BEEF, 32'h0);
    probe("mtlo_busy", 1'b1, 1'b0, 1'b1, cur_hi, cur_lo);
    issue(F_MULTU, 32'd9, 32'd9);
    probe("start_busy", 1'b1, 1'b0, 1'b1, cur_hi, cur_lo);
    wait_done("mult_2x3");
    step();

    // Reset asserted in cycle 10 of a MULT: abandoned, no late done
    issue(F_MULT, 32'd9, 32'd9);
    repeat (9) step();
    reset = 1'b0;
    #1;
    probe("rst_mid", 1'b0, 1'b0, 1'b1, '0, '0);
    step();
    reset = 1'b1;
    repeat (40) step();
    probe("after_rst", 1'b0, 1'b0, 1'b1, '0, '0);
    step();

    finish_req = 1'b1;
    step(); step();
  end

endmodule
